// File: rtl/reference_gen_if.sv
// Phase-step handshake bundle between a phase detector (master) and the reference generator (slave).
interface reference_gen_if #(
  parameter int PDET_WIDTH = 8
);
  logic [PDET_WIDTH-1:0] phase_step_i;
  logic                  step_valid_i;
  logic                  step_ready_o;

  modport master (output phase_step_i, output step_valid_i, input step_ready_o);
  modport slave  (input phase_step_i, input step_valid_i, output step_ready_o);
endinterface

// File: rtl/reference_gen.sv
// Programmable square-wave reference for an ADPLL: half period H, with one-shot signed phase steps
// folded into the length of the next HIGH phase so that every later rising edge moves by the step.
module reference_gen #(
  parameter int                  HP_WIDTH   = 8,
  parameter int                  PDET_WIDTH = 8,
  parameter logic [HP_WIDTH-1:0] DEFAULT_HP = 8'd26
) (
  input  logic                fpga_clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic [HP_WIDTH-1:0] half_period_i,
  reference_gen_if.slave      step_if,
  output logic                ref_o,
  output logic                edge_o
);

  localparam int CW = HP_WIDTH + 1;
  localparam int SW = ((HP_WIDTH > PDET_WIDTH) ? HP_WIDTH : PDET_WIDTH) + 3;

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  state_t                       r_state, w_nextState;
  logic [CW-1:0]                r_count, w_nextCount;
  logic [CW-1:0]                r_highLen, w_nextHighLen;
  logic [HP_WIDTH-1:0]          r_halfPeriod, w_nextHalfPeriod;
  logic signed [PDET_WIDTH-1:0] r_step, w_nextStep;
  logic                         r_pending, w_nextPending;
  logic                         r_applying, w_nextApplying;
  logic                         r_ref, r_edge;
  logic                         w_ready, w_accept, w_enterHigh;
  logic [HP_WIDTH-1:0]          w_hSample;
  logic signed [SW-1:0]         w_sum;
  logic [CW-1:0]                w_clampedLen;

  // Length of a HIGH phase starting now: sampled H plus any pending step, limited to [1, 2^CW-1].
  assign w_hSample    = (half_period_i == '0) ? HP_WIDTH'(1) : half_period_i;
  assign w_sum        = $signed({{(SW-HP_WIDTH){1'b0}}, w_hSample}) + (r_pending ? SW'(r_step) : '0);
  assign w_clampedLen = (w_sum[SW-1] || (w_sum == '0)) ? CW'(1) :
                        (|w_sum[SW-2:CW])              ? '1     : w_sum[CW-1:0];

  // A step stays "busy" from acceptance until the HIGH phase that absorbs it has finished.
  assign w_ready              = (r_state != IDLE) && !r_pending && !r_applying;
  assign w_accept             = step_if.step_valid_i && w_ready;
  assign step_if.step_ready_o = w_ready;
  assign ref_o                = r_ref;
  assign edge_o               = r_edge;

  always_comb begin
    w_nextState      = r_state;
    w_nextCount      = r_count;
    w_nextHighLen    = r_highLen;
    w_nextHalfPeriod = r_halfPeriod;
    w_nextStep       = r_step;
    w_nextPending    = r_pending;
    w_nextApplying   = r_applying;
    w_enterHigh      = 1'b0;

    if (w_accept) begin
      w_nextStep    = $signed(step_if.phase_step_i);
      w_nextPending = 1'b1;
    end

    case (r_state)
      IDLE: begin
        w_nextCount = '0;
        if (enable_i) w_enterHigh = 1'b1;
      end
      HIGH: begin
        if (!enable_i) begin
          w_nextState    = IDLE;
          w_nextCount    = '0;
          w_nextPending  = 1'b0;
          w_nextApplying = 1'b0;
        end else if (r_count == r_highLen - CW'(1)) begin
          w_nextState    = LOW;
          w_nextCount    = '0;
          w_nextApplying = 1'b0;
        end else begin
          w_nextCount = r_count + CW'(1);
        end
      end
      LOW: begin
        if (!enable_i) begin
          w_nextState    = IDLE;
          w_nextCount    = '0;
          w_nextPending  = 1'b0;
          w_nextApplying = 1'b0;
        end else if (r_count == {1'b0, r_halfPeriod} - CW'(1)) begin
          w_enterHigh = 1'b1;
        end else begin
          w_nextCount = r_count + CW'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCount = '0;
      end
    endcase

    // A step accepted on this very edge is not yet in r_pending, so it waits for the next entry.
    if (w_enterHigh) begin
      w_nextState      = HIGH;
      w_nextCount      = '0;
      w_nextHalfPeriod = w_hSample;
      w_nextHighLen    = w_clampedLen;
      if (r_pending) begin
        w_nextPending  = 1'b0;
        w_nextApplying = 1'b1;
      end
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_halfPeriod <= DEFAULT_HP;
      r_highLen    <= CW'(DEFAULT_HP);
      r_step       <= '0;
      r_pending    <= 1'b0;
      r_applying   <= 1'b0;
      r_ref        <= 1'b0;
      r_edge       <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_count      <= w_nextCount;
      r_halfPeriod <= w_nextHalfPeriod;
      r_highLen    <= w_nextHighLen;
      r_step       <= w_nextStep;
      r_pending    <= w_nextPending;
      r_applying   <= w_nextApplying;
      r_ref        <= (w_nextState == HIGH);
      r_edge       <= w_enterHigh;
    end
  end

endmodule

// File: tb/tb_reference_gen.sv
// Bench for reference_gen: an absolute-time schedule model checked every cycle, plus directed
// period measurements with hand-computed lengths, then a randomized run.
module tb_reference_gen;

  localparam int HPW = 8;
  localparam int PW  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [HPW-1:0] hp;
  logic           refO;
  logic           edgeO;

  reference_gen_if #(.PDET_WIDTH(PW)) sif ();

  reference_gen #(.HP_WIDTH(HPW), .PDET_WIDTH(PW), .DEFAULT_HP(8'd26)) dut (
    .fpga_clk_i   (clk),
    .reset_i      (rst),
    .enable_i     (en),
    .half_period_i(hp),
    .step_if      (sif),
    .ref_o        (refO),
    .edge_o       (edgeO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit checking = 1'b0;

  // Model: absolute edge numbers of the next fall and rise, plus step bookkeeping.
  int n = 0;
  bit mRun = 1'b0, mPend = 1'b0, mBusy = 1'b0;
  int mRise = 0, mFall = 0, mLast = -1, mStep = 0;
  bit expRef = 1'b0, expEdge = 1'b0, expReady = 1'b0;

  task automatic modelStep();
    bit acc;
    int h, hh;
    acc = sif.step_valid_i && expReady;
    n++;
    if (rst || !en) begin
      mRun  = 1'b0;
      mPend = 1'b0;
      mBusy = 1'b0;
    end else begin
      if (!mRun || n == mRise) begin
        mRun = 1'b1;
        h    = (hp == 0) ? 1 : int'(hp);
        hh   = h + (mPend ? mStep : 0);
        if (hh < 1) hh = 1;
        mLast = n;
        mFall = n + hh;
        mRise = mFall + h;
        if (mPend) begin
          mBusy = 1'b1;
          mPend = 1'b0;
        end
      end else if (n == mFall) begin
        mBusy = 1'b0;
      end
      if (acc) begin
        mPend = 1'b1;
        mStep = int'($signed(sif.phase_step_i));
      end
    end
    expRef   = mRun && (n < mFall);
    expEdge  = mRun && (n == mLast);
    expReady = mRun && !mPend && !mBusy;
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  initial forever begin
    @(negedge clk);
    if (checking) begin
      checkOutput("model ref_o", int'(refO), int'(expRef));
      checkOutput("model edge_o", int'(edgeO), int'(expEdge));
      checkOutput("model step_ready_o", int'(sif.step_ready_o), int'(expReady));
    end
  end

  task automatic applyStimulus(input bit enV, input int hpV, input bit validV, input int stepV);
    en               = enV;
    hp               = HPW'(hpV);
    sif.step_valid_i = validV;
    sif.phase_step_i = PW'(stepV);
  endtask

  task automatic waitEdge();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (edgeO) return;
    end
    checkOutput("waitEdge timeout", 0, 1);
  endtask

  // Starts on a cycle with edge_o high; returns on the next such cycle.
  task automatic measure(output int hi, output int lo);
    hi = 0;
    lo = 0;
    for (int i = 0; i < 1000 && refO; i++) begin hi++; @(negedge clk); end
    for (int i = 0; i < 1000 && !edgeO; i++) begin lo++; @(negedge clk); end
  endtask

  task automatic checkPeriod(input string name, input int hiExp, input int loExp);
    int hi, lo;
    measure(hi, lo);
    checkOutput({name, " high"}, hi, hiExp);
    checkOutput({name, " low"}, lo, loExp);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 4, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    checking = 1'b1;
    checkOutput("reset ref_o", int'(refO), 0);
    checkOutput("reset edge_o", int'(edgeO), 0);
    checkOutput("reset ready", int'(sif.step_ready_o), 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 4, 1'b0, 0);
    @(negedge clk);
    checkOutput("first rise ref_o", int'(refO), 1);
    checkOutput("first rise edge_o", int'(edgeO), 1);
    checkPeriod("H4 p1", 4, 4);
    checkPeriod("H4 p2", 4, 4);

    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 4, 1'b1, 3);
    @(negedge clk);
    applyStimulus(1'b1, 4, 1'b0, 0);
    waitEdge();
    checkPeriod("step+3", 7, 4);
    checkPeriod("after step+3", 4, 4);

    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 4, 1'b1, -10);
    @(negedge clk);
    applyStimulus(1'b1, 4, 1'b0, 0);
    waitEdge();
    checkPeriod("step-10 clamp", 1, 4);

    repeat (7) @(negedge clk);
    applyStimulus(1'b1, 4, 1'b1, 2);
    @(negedge clk);
    applyStimulus(1'b1, 4, 1'b0, 0);
    checkOutput("entry-step edge_o", int'(edgeO), 1);
    checkPeriod("entry-step current", 4, 4);
    checkPeriod("entry-step next", 6, 4);

    applyStimulus(1'b1, 6, 1'b0, 0);
    checkPeriod("H change current", 4, 4);
    checkPeriod("H change next", 6, 6);

    applyStimulus(1'b1, 0, 1'b0, 0);
    checkPeriod("H0 pending", 6, 6);
    checkPeriod("H0", 1, 1);
    applyStimulus(1'b1, 4, 1'b0, 0);
    checkPeriod("H0 last", 1, 1);
    checkPeriod("H4 again", 4, 4);

    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 4, 1'b1, 2);
    @(negedge clk);
    applyStimulus(1'b1, 4, 1'b1, 5);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 4, 1'b0, 0);
    waitEdge();
    checkPeriod("second step ignored", 6, 4);

    applyStimulus(1'b1, 4, 1'b1, 3);
    @(negedge clk);
    applyStimulus(1'b1, 4, 1'b0, 0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checkOutput("disable ref_o", int'(refO), 0);
    checkOutput("disable ready", int'(sif.step_ready_o), 0);
    en = 1'b1;
    @(negedge clk);
    checkOutput("re-enable edge_o", int'(edgeO), 1);
    checkPeriod("step discarded by disable", 4, 4);

    applyStimulus(1'b1, 4, 1'b1, 3);
    @(negedge clk);
    applyStimulus(1'b1, 4, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid reset ref_o", int'(refO), 0);
    checkOutput("mid reset ready", int'(sif.step_ready_o), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post reset edge_o", int'(edgeO), 1);
    checkPeriod("step discarded by reset", 4, 4);

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 29) == 0) hp = HPW'($urandom_range(0, 7));
      sif.step_valid_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) sif.phase_step_i = PW'($urandom);
      else sif.phase_step_i = PW'(int'($urandom_range(0, 12)) - 6);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/reference_gen.md
REFERENCE_GEN -- requirements
Module: reference_gen

Interface
REQ-001 Parameter HP_WIDTH, default 8: width of the half-period setting in fpga_clk_i cycles.
REQ-002 Parameter PDET_WIDTH, default 8: width of the signed phase-step word, matching the phase-detector error width.
REQ-003 Parameter DEFAULT_HP, default 8'd26: informative only; the reset value of the held half-period register.
REQ-004 fpga_clk_i  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset_i  input  1  reset; synchronous, active-high.
REQ-006 enable_i  input  1  run request; low forces IDLE.
REQ-007 half_period_i  input  HP_WIDTH  requested half period H in fpga_clk_i cycles; 0 SHALL be treated as 1.
REQ-008 phase_step_i  input  PDET_WIDTH  signed one-shot phase step in fpga_clk_i cycles; positive delays, negative advances.
REQ-009 step_valid_i  input  1  phase_step_i valid.
REQ-010 step_ready_o  output  1  block can accept a step; transfer when step_valid_i and step_ready_o are both high on one clock edge.
REQ-011 ref_o  output  1  generated reference square wave, registered, glitch-free; drives an ADPLL reference input.
REQ-012 edge_o  output  1  one-cycle pulse, high in exactly the cycles in which ref_o is 1 after being 0.

Function
REQ-013 States SHALL be IDLE, HIGH and LOW; a phase counter of HP_WIDTH+1 bits SHALL count fpga_clk_i cycles within the current phase.
REQ-014 IDLE: ref_o=0, edge_o=0, step_ready_o=0, counter=0; with enable_i=1, go to HIGH on the next edge.
REQ-015 On each entry to HIGH, sample half_period_i into the held H register, so H changes only at rising edges of ref_o.
REQ-016 HIGH lasts Hh cycles of ref_o=1, then LOW lasts H cycles of ref_o=0, then HIGH again; with no step, Hh=H and the period is 2H.
REQ-017 An accepted step SHALL be held pending and applied to the next HIGH entry after acceptance: Hh = H + step.
REQ-018 Clamp: if H + step < 1, then Hh = 1; the arithmetic SHALL be signed, at least HP_WIDTH+2 bits wide, with no wrap-around.
REQ-019 A step accepted in the same cycle as a HIGH entry SHALL apply to the following HIGH entry, not to the current one.
REQ-020 step_ready_o=1 only in HIGH or LOW with no step pending; it SHALL fall in the cycle after acceptance and rise in the cycle after the HIGH phase that consumed the step ends.
REQ-021 The net effect of a step k (unclamped) SHALL be to shift all later rising edges by exactly k cycles.
REQ-022 edge_o SHALL be asserted in the first cycle of every HIGH phase, including the first cycle after leaving IDLE.
REQ-023 enable_i low in HIGH or LOW: enter IDLE on the next edge, and discard any pending step.
REQ-024 step_valid_i while step_ready_o=0 SHALL be ignored; no queueing beyond one pending step.

Reset
REQ-025 reset_i=1 SHALL override all other inputs, giving on the next edge: state IDLE, counter 0, ref_o 0, edge_o 0, step_ready_o 0, no pending step, H=DEFAULT_HP.
REQ-026 Reset asserted mid-phase SHALL truncate the phase immediately, with no partial pulse after the reset edge.
REQ-027 After reset is released, operation SHALL resume per REQ-014 once enable_i=1.

Verification
REQ-028 Reset, then enable_i=1 with H=4 -> ref_o rises on the edge after enable, then 4 high / 4 low repeating; edge_o is 1 for one cycle per period.
REQ-029 H=4, change half_period_i to 6 mid-HIGH -> current period is 8 cycles, next period is 12 cycles (6/6).
REQ-030 H=4, step +3 accepted in LOW -> next HIGH is 7 cycles, later periods are 8; step_ready_o is low from the cycle after acceptance until the cycle after that HIGH phase ends.
REQ-031 H=4, step -10 -> clamped, next HIGH is 1 cycle; a step accepted on a HIGH-entry cycle -> current HIGH is unaffected.
REQ-032 half_period_i=0 -> ref_o toggles every cycle (period 2); a second step_valid_i while a step is pending is ignored.
REQ-033 enable_i deasserted, or reset_i asserted, mid-HIGH with a step pending -> ref_o=0 and step_ready_o=0 on the next edge; on re-enable the first HIGH is H cycles (the step was discarded).
